// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into a stall vector, sequences
// exception/ERET flushes with a PC redirect, and watches for over-long stalls.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int          FLUSH_CYCLES  = 1,
    parameter int          STALL_TIMEOUT = 255,
    parameter int          CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        clr_timeout,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
);

    localparam logic [31:0]      ERET_CODE  = 32'h0000_000e;
    localparam logic [31:0]      FLUSH_LOAD = 32'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(STALL_TIMEOUT);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state;
    logic [31:0]      flush_cnt;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] wd_cnt;
    logic             exc_take;
    logic [31:0]      exc_pc;

    // Outputs are combinational so an exception flushes in the cycle it appears;
    // reset forces them quiet even while an exception code is present.
    always_comb begin
        exc_take = (state == RUN) && (excepttype_i != 32'h0);
        exc_pc   = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        stall    = 6'b000000;
        flush    = 1'b0;
        new_pc   = pc_q;
        if (!rst) begin
            new_pc = 32'h0;
        end else if (state == FLUSH) begin
            flush = 1'b1;
        end else if (exc_take) begin
            flush  = 1'b1;
            new_pc = exc_pc;
        end else if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (stallreq_ex) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            flush_cnt     <= 32'h0;
            pc_q          <= 32'h0;
            wd_cnt        <= '0;
            stall_timeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (exc_take) begin
                        pc_q <= exc_pc;
                        if (FLUSH_CYCLES > 1) begin
                            state     <= FLUSH;
                            flush_cnt <= FLUSH_LOAD;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 32'h1;
                    if (flush_cnt == 32'h1) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase

            // Watchdog counts consecutive stalled cycles; any unstalled cycle restarts it.
            if (stall != 6'b000000) begin
                if (wd_cnt != {CNT_W{1'b1}}) begin
                    wd_cnt <= wd_cnt + CNT_W'(1);
                end
            end else begin
                wd_cnt <= '0;
            end

            if (wd_cnt >= WD_LIMIT) begin
                stall_timeout <= 1'b1;
            end else if (clr_timeout) begin
                stall_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (3-cycle and 1-cycle flush) checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id, ex, mem, clr;
    logic [31:0] exc, epc;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b;
    logic [31:0] pc_a, pc_b;
    logic        to_a, to_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(3), .STALL_TIMEOUT(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .stallreq_id(id), .stallreq_ex(ex), .stallreq_mem(mem),
        .excepttype_i(exc), .cp0_epc_i(epc), .clr_timeout(clr),
        .stall(stall_a), .flush(flush_a), .new_pc(pc_a), .stall_timeout(to_a)
    );

    pipe_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(1), .STALL_TIMEOUT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .stallreq_id(id), .stallreq_ex(ex), .stallreq_mem(mem),
        .excepttype_i(exc), .cp0_epc_i(epc), .clr_timeout(clr),
        .stall(stall_b), .flush(flush_b), .new_pc(pc_b), .stall_timeout(to_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: remaining flush cycles, latched redirect, stalled-run length, flag.
    int          fc_p   [2] = '{3, 1};
    int          maxr_p [2] = '{255, 7};
    int          m_left [2] = '{0, 0};
    int          m_run  [2] = '{0, 0};
    logic [31:0] m_pc   [2] = '{32'h0, 32'h0};
    logic        m_to   [2] = '{1'b0, 1'b0};

    logic [5:0]  stall_v [2];
    logic        flush_v [2];
    logic [31:0] pc_v    [2];
    logic        to_v    [2];
    assign stall_v[0] = stall_a;  assign stall_v[1] = stall_b;
    assign flush_v[0] = flush_a;  assign flush_v[1] = flush_b;
    assign pc_v[0]    = pc_a;     assign pc_v[1]    = pc_b;
    assign to_v[0]    = to_a;     assign to_v[1]    = to_b;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [5:0]  es;
            logic        ef, et, set_now;
            logic [31:0] ep;
            es = 6'd0; ef = 1'b0; et = 1'b0; ep = 32'h0;
            if (!rst) begin
                m_left[i] = 0; m_run[i] = 0; m_pc[i] = 32'h0; m_to[i] = 1'b0;
            end else begin
                ep = m_pc[i];
                if (m_left[i] > 0) begin
                    ef = 1'b1;
                    m_left[i]--;
                end else if (exc != 32'h0) begin
                    ef = 1'b1;
                    ep = (exc == 32'he) ? epc : 32'h20;
                    m_pc[i]   = ep;
                    m_left[i] = fc_p[i] - 1;
                end else begin
                    es = mem ? 6'h1f : ex ? 6'h0f : id ? 6'h07 : 6'h00;
                end
                et      = m_to[i];
                set_now = (m_run[i] >= 4);
                m_run[i] = (es != 6'd0) ? ((m_run[i] == maxr_p[i]) ? m_run[i] : m_run[i] + 1) : 0;
                m_to[i]  = set_now ? 1'b1 : (clr ? 1'b0 : m_to[i]);
            end
            chk($sformatf("stall[%0d]", i), {26'd0, stall_v[i]}, {26'd0, es});
            chk($sformatf("flush[%0d]", i), {31'd0, flush_v[i]}, {31'd0, ef});
            chk($sformatf("timeout[%0d]", i), {31'd0, to_v[i]}, {31'd0, et});
            if (ef || !rst) chk($sformatf("new_pc[%0d]", i), pc_v[i], ep);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id = 1'b0; ex = 1'b0; mem = 1'b0; clr = 1'b0; exc = 32'h0;
    endtask

    initial begin
        rst = 1'b0;
        id = 1'b1; ex = 1'b0; mem = 1'b1; clr = 1'b0;
        exc = 32'h0000_0003; epc = 32'hdead_beef;

        // Reset with busy inputs
        step(); step();
        chk("rst_stall", {26'd0, stall_a}, 32'h0);
        chk("rst_flush", {31'd0, flush_a}, 32'h0);
        chk("rst_new_pc", pc_a, 32'h0);
        chk("rst_timeout", {31'd0, to_a}, 32'h0);
        idle_inputs();
        rst = 1'b1;
        step();

        // Stall priority
        id = 1'b1; ex = 1'b1; mem = 1'b0; #1;
        chk("prio_ex", {26'd0, stall_a}, 32'h0000_000f);
        mem = 1'b1; #1;
        chk("prio_mem", {26'd0, stall_a}, 32'h0000_001f);
        ex = 1'b0; mem = 1'b0; #1;
        chk("prio_id", {26'd0, stall_a}, 32'h0000_0007);
        step();
        idle_inputs();
        step(); step();
        clr = 1'b1; step(); clr = 1'b0;

        // Exception on dut_a lasts exactly three flush cycles; later codes ignored
        exc = 32'h1; mem = 1'b1; #1;
        chk("exc_c1_flush", {31'd0, flush_a}, 32'h1);
        chk("exc_c1_stall", {26'd0, stall_a}, 32'h0);
        chk("exc_c1_pc", pc_a, 32'h20);
        step();
        exc = 32'h5; #1;
        chk("exc_c2_flush", {31'd0, flush_a}, 32'h1);
        chk("exc_c2_pc", pc_a, 32'h20);
        step();
        exc = 32'he; epc = 32'h1234; #1;
        chk("exc_c3_flush", {31'd0, flush_a}, 32'h1);
        chk("exc_c3_pc", pc_a, 32'h20);
        step();
        idle_inputs(); #1;
        chk("exc_c4_flush", {31'd0, flush_a}, 32'h0);
        step();

        // ERET on dut_b (single flush cycle)
        exc = 32'he; epc = 32'h0000_1234; #1;
        chk("eret_flush", {31'd0, flush_b}, 32'h1);
        chk("eret_pc", pc_b, 32'h1234);
        step();
        exc = 32'h0; #1;
        chk("eret_next_flush", {31'd0, flush_b}, 32'h0);
        step(); step(); step();

        // Watchdog: ex held six cycles
        clr = 1'b1; step(); clr = 1'b0;
        ex = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 4) chk("wd_edge4", {31'd0, to_a}, 32'h0);
            if (k == 5) chk("wd_edge5", {31'd0, to_a}, 32'h1);
        end
        ex = 1'b0;
        step();
        chk("wd_sticky", {31'd0, to_a}, 32'h1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("wd_clear", {31'd0, to_a}, 32'h0);
        for (int r = 0; r < 4; r++) begin
            ex = 1'b1; step(); step(); step();
            ex = 1'b0; step();
        end
        chk("wd_short_runs", {31'd0, to_a}, 32'h0);

        // Async reset during the second flush cycle
        exc = 32'h7; step();
        exc = 32'h0; #1;
        chk("arst_flush_before", {31'd0, flush_a}, 32'h1);
        rst = 1'b0; #1;
        chk("arst_flush_drop", {31'd0, flush_a}, 32'h0);
        step();
        rst = 1'b1; id = 1'b1; #1;
        chk("arst_run_stall", {26'd0, stall_a}, 32'h0000_0007);
        step();
        idle_inputs();

        // Randomized traffic with alternating light/heavy stall phases
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic heavy;
            step();
            heavy = ((cyc / 100) % 2) == 1;
            rst   = ($urandom_range(0, 199) != 0);
            id    = ($urandom_range(0, 2) == 0);
            ex    = heavy ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
            mem   = ($urandom_range(0, 4) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            epc   = $urandom;
            if ($urandom_range(0, 15) == 0)
                exc = ($urandom_range(0, 1) == 1) ? 32'he : 32'($urandom_range(1, 40));
            else
                exc = 32'h0;
        end
        step();
        rst = 1'b1;
        idle_inputs();
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
